// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: FSM states, decoded memory ops,
// byte-strobe constants and small decode helpers.
package mem_stage_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state;

    typedef enum logic [3:0] {LB, LH, LW, LBU, LHU, SB, SH, SW, NONE} mem_op;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_B    = 4'b0001;
    localparam logic [3:0] WSTRB_H    = 4'b0011;
    localparam logic [3:0] WSTRB_W    = 4'b1111;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
    } instructions;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } regvpair;

    function automatic mem_op decode_op(input instructions i);
        if (i.lb)       return LB;
        else if (i.lh)  return LH;
        else if (i.lw)  return LW;
        else if (i.lbu) return LBU;
        else if (i.lhu) return LHU;
        else if (i.sb)  return SB;
        else if (i.sh)  return SH;
        else if (i.sw)  return SW;
        else            return NONE;
    endfunction

    function automatic logic is_store(input mem_op op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic misaligned(input mem_op op, input logic [1:0] a);
        case (op)
            LH, LHU, SH: return a[0];
            LW, SW:      return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering: store strobes/replicated data and load extraction with
// sign/zero extension, all from the op and the low address bits.
module mem_lane_unit
    import mem_stage_pkg::*;
(
    input  mem_op       op,
    input  logic [1:0]  a,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_val
);

    logic [3:0][7:0] rbytes;
    logic [7:0]      sel_b;
    logic [15:0]     sel_h;

    assign rbytes = rdata;
    assign sel_b  = rbytes[a];
    assign sel_h  = a[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        wstrb = WSTRB_NONE;
        wdata = '0;
        case (op)
            SB: begin
                wstrb = WSTRB_B << a;
                wdata = {4{rs2[7:0]}};
            end
            SH: begin
                wstrb = WSTRB_H << {a[1], 1'b0};
                wdata = {2{rs2[15:0]}};
            end
            SW: begin
                wstrb = WSTRB_W;
                wdata = rs2;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (op)
            LB:      load_val = {{24{sel_b[7]}}, sel_b};
            LBU:     load_val = {24'd0, sel_b};
            LH:      load_val = {{16{sel_h[15]}}, sel_h};
            LHU:     load_val = {16'd0, sel_h};
            LW:      load_val = rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: valid/ready request then response on the data bus, with
// a WAIT timeout. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enabled,
    input  instructions instr,
    input  regvpair     register,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        completed,
    output logic [31:0] result,
    output logic        exc_misaligned,
    output logic        bus_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp_valid
);

    localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    mem_state    state, next_state;
    mem_op       op_in, op_q;
    logic [31:0] addr_q, rs2_q, tmo_cnt, load_val;
    logic        accept, misal, timeout_hit, skip_bus;
    logic        unused_rs1;

    assign unused_rs1  = ^register.rs1;
    assign op_in       = decode_op(instr);
    assign accept      = (state == IDLE) && enabled;
    assign timeout_hit = (TIMEOUT != 0) && !mem_resp_valid && (tmo_cnt == TMO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    assign misal = misaligned(op_in, alu_result[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         exc_misaligned <= 1'b0;
        else if (accept) exc_misaligned <= misal;
    end
`else
    assign misal          = 1'b0;
    assign exc_misaligned = 1'b0;
`endif

    // Non-memory ops and trapped accesses never touch the bus.
    assign skip_bus = (op_in == NONE) || misal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (enabled) next_state = skip_bus ? DONE : REQ;
            REQ:  if (mem_req_ready) next_state = WAIT;
            WAIT: if (mem_resp_valid || timeout_hit) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        completed     = (state == DONE);
        mem_req_valid = (state == REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= NONE;
            addr_q  <= '0;
            rs2_q   <= '0;
            result  <= '0;
            bus_err <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (state == WAIT && !mem_resp_valid) ? tmo_cnt + 32'd1 : 32'd0;
            if (accept) begin
                bus_err <= 1'b0;
                if (skip_bus) begin
                    result <= alu_result;
                    op_q   <= NONE;
                end else begin
                    op_q   <= op_in;
                    addr_q <= alu_result;
                    rs2_q  <= register.rs2;
                end
            end else if (state == WAIT) begin
                if (mem_resp_valid) begin
                    result <= is_store(op_q) ? 32'd0 : load_val;
                end else if (timeout_hit) begin
                    result  <= 32'd0;
                    bus_err <= 1'b1;
                end
            end
        end
    end

    // Bus fields come straight from the latched request, so they hold through REQ.
    assign mem_addr = {addr_q[31:2], 2'b00};
    assign mem_we   = is_store(op_q);

    mem_lane_unit u_lane (
        .op       (op_q),
        .a        (addr_q[1:0]),
        .rs2      (rs2_q),
        .rdata    (mem_rdata),
        .wstrb    (mem_wstrb),
        .wdata    (mem_wdata),
        .load_val (load_val)
    );

endmodule
